// File: rtl/regfile_pkg.sv
// regfile_pkg: shared CPU constants used by the register file, the MEM stage and decode.
package regfile_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port with reset/enable/r0 gating and write-back bypass.
module regfile_rd_port #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int NREG = 2 ** ADDR_W
) (
   input  logic              reset,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] regs [NREG],
   output logic [DATA_W-1:0] rdata
);
   import regfile_pkg::*;
   always_comb
      rdata = (reset || !re || raddr == ADDR_W'(REG_ZERO)) ? DATA_W'(ZERO_WORD)
            : (we && waddr == raddr) ? wdata
            : regs[raddr];
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 register file, one write port, two bypassed combinational read ports.
module regfile #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int NREG = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);
   import regfile_pkg::*;
   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   // r0 is never written, so after the first reset it stays zero
   always_comb begin
      regs_d = regs_q;
      if (we && waddr != ADDR_W'(REG_ZERO)) regs_d[waddr] = wdata;
   end
   always_ff @(posedge clk)
      if (reset) regs_q <= '{default: DATA_W'(ZERO_WORD)};
      else regs_q <= regs_d;
   regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) u_rd1 (
      .reset(reset), .re(re1), .raddr(raddr1), .we(we), .waddr(waddr), .wdata(wdata),
      .regs(regs_q), .rdata(rdata1)
   );
   regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) u_rd2 (
      .reset(reset), .re(re2), .raddr(raddr2), .we(we), .waddr(waddr), .wdata(wdata),
      .regs(regs_q), .rdata(rdata2)
   );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed vectors plus a randomized regression, checked through an expectation queue.
module tb_regfile;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic        re1 = 1'b0;
   logic [4:0]  raddr1 = '0;
   logic [31:0] rdata1;
   logic        re2 = 1'b0;
   logic [4:0]  raddr2 = '0;
   logic [31:0] rdata2;

   typedef struct {
      string       name;
      logic [31:0] e1;
      logic [31:0] e2;
   } exp_t;
   exp_t sb[$];
   int n_vec = 0;
   int n_err = 0;
   logic [31:0] m [32];

   regfile dut (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
   );

   always #5 clk = ~clk;

   // Outputs are combinational: the vector driven after a rising edge is checked on the falling edge.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         n_vec++;
         if (rdata1 !== e.e1 || rdata2 !== e.e2) begin
            n_err++;
            $display("FAIL %s: rdata1=%h rdata2=%h expected %h %h", e.name, rdata1, rdata2, e.e1, e.e2);
         end
      end
   end

   task automatic apply(input string name, input logic rst, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic r1, input logic [4:0] a1,
                        input logic r2, input logic [4:0] a2, input logic [31:0] x1, input logic [31:0] x2);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; we = w; waddr = wa; wdata = wd;
      re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
      e.name = name; e.e1 = x1; e.e2 = x2;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] model_rd(input logic rst, input logic r, input logic [4:0] a,
                                            input logic w, input logic [4:0] wa, input logic [31:0] wd);
      if (rst || !r || a == 5'd0) return 32'h0;
      if (w && wa == a) return wd;
      return m[a];
   endfunction

   initial begin
      // name           rst we wa     wdata          re1 a1     re2 a2     exp1           exp2
      apply("reset_init",  1, 0, 5'd0,  32'h0,         1, 5'd5,  1, 5'd31, 32'h0,         32'h0);
      apply("wr_r5_byp",   0, 1, 5'd5,  32'hDEADBEEF,  1, 5'd5,  1, 5'd31, 32'hDEADBEEF,  32'h0);
      apply("wr_r31_byp",  0, 1, 5'd31, 32'h1234,      1, 5'd5,  1, 5'd31, 32'hDEADBEEF,  32'h1234);
      apply("reset_rd",    1, 0, 5'd0,  32'h0,         1, 5'd5,  1, 5'd31, 32'h0,         32'h0);
      apply("post_reset",  0, 0, 5'd0,  32'h0,         1, 5'd5,  1, 5'd31, 32'h0,         32'h0);
      apply("r0_write",    0, 1, 5'd0,  32'hFFFFFFFF,  1, 5'd0,  1, 5'd0,  32'h0,         32'h0);
      apply("r0_read",     0, 0, 5'd0,  32'h0,         1, 5'd0,  1, 5'd0,  32'h0,         32'h0);
      apply("wr_r7_gated", 0, 1, 5'd7,  32'h11,        0, 5'd7,  0, 5'd7,  32'h0,         32'h0);
      apply("byp_r7_dual", 0, 1, 5'd7,  32'h22,        1, 5'd7,  1, 5'd7,  32'h22,        32'h22);
      apply("rd_r7",       0, 0, 5'd7,  32'h0,         1, 5'd7,  1, 5'd7,  32'h22,        32'h22);
      apply("wr_r3",       0, 1, 5'd3,  32'hA,         0, 5'd3,  0, 5'd4,  32'h0,         32'h0);
      apply("wr_r4_byp",   0, 1, 5'd4,  32'hB,         1, 5'd3,  1, 5'd4,  32'hA,         32'hB);
      apply("dual_rd",     0, 0, 5'd0,  32'h0,         1, 5'd3,  1, 5'd4,  32'hA,         32'hB);
      apply("re2_off",     0, 0, 5'd0,  32'h0,         1, 5'd3,  0, 5'd4,  32'hA,         32'h0);
      apply("rst_vs_wr",   1, 1, 5'd9,  32'h55,        1, 5'd9,  1, 5'd3,  32'h0,         32'h0);
      apply("rd_r9_lost",  0, 0, 5'd0,  32'h0,         1, 5'd9,  1, 5'd3,  32'h0,         32'h0);
      apply("wr_after_rst",0, 1, 5'd9,  32'h66,        1, 5'd7,  1, 5'd9,  32'h0,         32'h66);
      apply("rd_r9",       0, 0, 5'd0,  32'h0,         1, 5'd9,  1, 5'd9,  32'h66,        32'h66);
      apply("b2b_wr1",     0, 1, 5'd9,  32'h77,        0, 5'd9,  1, 5'd9,  32'h0,         32'h77);
      apply("b2b_wr2",     0, 1, 5'd9,  32'h88,        1, 5'd9,  1, 5'd9,  32'h88,        32'h88);
      apply("b2b_last",    0, 0, 5'd0,  32'h0,         1, 5'd9,  1, 5'd4,  32'h88,        32'h0);
      apply("rand_reset",  1, 0, 5'd0,  32'h0,         1, 5'd9,  1, 5'd9,  32'h0,         32'h0);
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         logic r, w, r1, r2;
         logic [4:0] wa, a1, a2;
         logic [31:0] wd;
         r  = ($urandom_range(49) == 0);
         w  = $urandom_range(1) == 1;
         wa = 5'($urandom_range(31));
         wd = $urandom;
         r1 = $urandom_range(3) != 0;
         r2 = $urandom_range(3) != 0;
         a1 = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
         a2 = ($urandom_range(3) == 0) ? a1 : 5'($urandom_range(31));
         apply("random", r, w, wa, wd, r1, a1, r2, a2,
               model_rd(r, r1, a1, w, wa, wd), model_rd(r, r2, a2, w, wa, wd));
         if (r) for (int i = 0; i < 32; i++) m[i] = 32'h0;
         else if (w && wa != 5'd0) m[wa] = wd;
      end
      for (int t = 0; t < 10 && sb.size() != 0; t++) @(posedge clk);
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
